// File: rtl/orion_pkg.sv
// Shared definitions for the sequence game: widths, blank code, player states and
// the difficulty-to-length mapping used by sequence_player.
package orion_pkg;

    localparam int ADDR_W   = 5;
    localparam int DIGIT_W  = 4;
    localparam int BASE_LEN = 4;
    localparam int LEN_STEP = 4;

    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SHOW,
        GAP,
        DONE
    } player_state_t;

    // Carried at ADDR_W+1 bits so a full-depth run (len == 2**ADDR_W) is representable.
    function automatic logic [ADDR_W:0] seq_len(input logic [1:0] diff);
        return (ADDR_W + 1)'(BASE_LEN + LEN_STEP * int'(diff));
    endfunction

endpackage

// File: rtl/sequence_player_hold_tick_counter.sv
// Counts timer tick pulses for one displayed digit; o_hit flags the tick that
// completes HOLD_TICKS and the count restarts from zero on that same edge.
module hold_tick_counter #(
    parameter int HOLD_TICKS = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_hit
);

    localparam int CNT_W = $clog2(HOLD_TICKS + 1);

    logic [CNT_W-1:0] r_count;

    assign o_hit = i_tick && !i_clear && (r_count == CNT_W'(HOLD_TICKS - 1));

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || o_hit) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sequence_player.sv
// Plays back the stored digit run from RAM port B onto the digit display, one digit
// per HOLD_TICKS timer ticks. Define SEQ_PLAYER_GAP_EN to blank the display for one tick between digits.
module sequence_player
    import orion_pkg::*;
#(
    parameter int HOLD_TICKS = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [1:0]         i_diff,
    input  logic               i_tick,
    output logic               o_tick_en,
    output logic [ADDR_W-1:0]  o_ram_addr,
    input  logic [DIGIT_W-1:0] i_ram_q,
    output logic [DIGIT_W-1:0] o_disp_digit,
    output logic               o_disp_valid,
    output logic               o_busy,
    output logic               o_done
);

    localparam int MAX_LEN = BASE_LEN + LEN_STEP * 3;

    if (MAX_LEN > (1 << ADDR_W)) begin : g_len_check
        $error("sequence_player: max length %0d exceeds RAM depth %0d", MAX_LEN, 1 << ADDR_W);
    end
    if (HOLD_TICKS < 1) begin : g_hold_check
        $error("sequence_player: HOLD_TICKS must be at least 1");
    end

    player_state_t      r_state, w_next;
    logic [ADDR_W-1:0]  r_idx, w_idx;
    logic [ADDR_W:0]    r_len, w_len;
    logic [ADDR_W-1:0]  r_ram_addr, w_ram_addr;
    logic [DIGIT_W-1:0] r_disp_digit, w_disp_digit;
    logic               r_disp_valid, w_disp_valid;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_tick_en, w_tick_en;
    logic               w_hit, w_last, w_show_tick, w_hold_clear;

    // Ticks only count once the registered state is SHOW; leaving SHOW discards a partial hold.
    assign w_show_tick  = i_tick && (r_state == SHOW);
    assign w_hold_clear = i_abort || (r_state != SHOW);
    assign w_last       = ({1'b0, r_idx} == r_len - (ADDR_W + 1)'(1));

    hold_tick_counter #(
        .HOLD_TICKS (HOLD_TICKS)
    ) u_hold (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_hold_clear),
        .i_tick  (w_show_tick),
        .o_hit   (w_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_ram_addr   <= '0;
            r_disp_digit <= BLANK_CODE;
            r_disp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tick_en    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_idx        <= w_idx;
            r_len        <= w_len;
            r_ram_addr   <= w_ram_addr;
            r_disp_digit <= w_disp_digit;
            r_disp_valid <= w_disp_valid;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_tick_en    <= w_tick_en;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        if (i_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (i_start) w_next = FETCH;
                FETCH: w_next = LATCH;
                LATCH: w_next = SHOW;
                SHOW: begin
                    if (w_hit) begin
                        if (w_last) begin
                            w_next = DONE;
                        end else begin
`ifdef SEQ_PLAYER_GAP_EN
                            w_next = GAP;
`else
                            w_next = FETCH;
`endif
                        end
                    end
                end
                GAP:   if (i_tick) w_next = FETCH;
                DONE:  w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and datapath, derived from the transition taken.
    always_comb begin
        w_idx        = r_idx;
        w_len        = r_len;
        w_ram_addr   = r_ram_addr;
        w_disp_digit = r_disp_digit;
        w_disp_valid = r_disp_valid;
        w_busy       = (w_next != IDLE);
        w_done       = (w_next == DONE);
        w_tick_en    = (w_next == SHOW) || (w_next == GAP);
        if (i_abort) begin
            w_idx        = '0;
            w_ram_addr   = '0;
            w_disp_digit = BLANK_CODE;
            w_disp_valid = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_len      = seq_len(i_diff);
                        w_idx      = '0;
                        w_ram_addr = '0;
                    end
                end
                LATCH: begin
                    w_disp_digit = i_ram_q;
                    w_disp_valid = 1'b1;
                end
                SHOW: begin
                    if (w_hit && w_last) begin
                        w_idx      = '0;
                        w_ram_addr = '0;
                    end else if (w_hit) begin
                        w_idx      = r_idx + ADDR_W'(1);
                        w_ram_addr = r_idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
            if ((w_next == GAP) || (w_next == DONE)) begin
                w_disp_digit = BLANK_CODE;
                w_disp_valid = 1'b0;
            end
        end
    end

    assign o_tick_en    = r_tick_en;
    assign o_ram_addr   = r_ram_addr;
    assign o_disp_digit = r_disp_digit;
    assign o_disp_valid = r_disp_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_sequence_player.sv
// Randomized bench for sequence_player: the expected show order is simply RAM[0..len-1]
// with len = BASE_LEN + LEN_STEP*diff taken at start; a synchronous RAM model feeds port B.
module tb_sequence_player;
    import orion_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [1:0]         diff;
    logic               tick;
    logic               tick_en;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DIGIT_W-1:0] ram_q;
    logic [DIGIT_W-1:0] disp_digit;
    logic               disp_valid;
    logic               busy;
    logic               done;

    logic [DIGIT_W-1:0] ram [0:(1 << ADDR_W) - 1];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_q <= ram[ram_addr];

    sequence_player dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_diff       (diff),
        .i_tick       (tick),
        .o_tick_en    (tick_en),
        .o_ram_addr   (ram_addr),
        .i_ram_q      (ram_q),
        .o_disp_digit (disp_digit),
        .o_disp_valid (disp_valid),
        .o_busy       (busy),
        .o_done       (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_ram_random();
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DIGIT_W'($urandom_range(0, 9));
    endtask

    // One complete playback; noise injects start pulses and diff changes while busy.
    task automatic run_seq(input logic [1:0] d, input int pmin, input int pmax, input bit noise);
        int len;
        int k;
        int cd;
        int done_cnt;
        int done_cyc;
        int last_tick;
        int max_addr;
        int blank_bad;
        int gap_ticks;
        int valid_drop;
        bit seen_valid;
        bit finished;
        logic [DIGIT_W-1:0] exp_q[$];
        logic [DIGIT_W-1:0] got_q[$];
        logic [DIGIT_W-1:0] got;
        len = BASE_LEN + LEN_STEP * int'(d);
        k = 0; cd = pmax - 1; done_cnt = 0; done_cyc = -100; last_tick = -100;
        max_addr = 0; blank_bad = 0; gap_ticks = 0; valid_drop = 0;
        seen_valid = 1'b0; finished = 1'b0;
        for (int i = 0; i < len; i++) exp_q.push_back(ram[i]);
        while (!finished && k < 5000) begin
            @(posedge clk); #1;
            start = (k == 0) || (noise && done_cnt == 0 && $urandom_range(0, 7) == 0);
            if (k == 0) diff = d;
            else if (noise) diff = 2'($urandom);
            if (cd == 0) begin
                tick = 1'b1;
                cd = $urandom_range(pmin, pmax) - 1;
            end else begin
                tick = 1'b0;
                cd--;
            end
            @(negedge clk);
            if (k == 1) begin
                check("addr_at_cycle1", ram_addr, 0);
                check("busy_at_cycle1", busy, 1);
            end
            if (k == 2) check("valid_low_cycle2", disp_valid, 0);
            if (k == 3) begin
                check("valid_at_cycle3", disp_valid, 1);
                check("digit_at_cycle3", disp_digit, exp_q[0]);
            end
            if (busy && int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            if (!disp_valid && disp_digit !== BLANK_CODE) blank_bad++;
            if (tick && tick_en && disp_valid) begin
                got_q.push_back(disp_digit);
                last_tick = k;
            end
            if (tick && tick_en && !disp_valid) gap_ticks++;
            if (seen_valid && busy && !done && !disp_valid) valid_drop++;
            if (disp_valid) seen_valid = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = k;
                    check("done_digit_blank", disp_digit, BLANK_CODE);
                    check("done_valid_low", disp_valid, 0);
                    check("done_tick_en_low", tick_en, 0);
                    check("done_busy_high", busy, 1);
                end
            end
            if (done_cnt > 0 && k == done_cyc + 1) check("busy_after_done", busy, 0);
            if (done_cnt > 0 && k == done_cyc + 6) finished = 1'b1;
            k++;
        end
        start = 1'b0;
        tick  = 1'b0;
        check("run_completed", finished, 1);
        check("digit_count", got_q.size(), len);
        for (int i = 0; i < len; i++) begin
            got = (i < got_q.size()) ? got_q[i] : 'x;
            check($sformatf("d%0d_digit%0d", d, i), got, exp_q[i]);
        end
        check("done_pulses", done_cnt, 1);
        check("done_after_last_tick", done_cyc, last_tick + 1);
        check("max_read_addr", max_addr, len - 1);
        check("blank_when_invalid", blank_bad, 0);
`ifdef SEQ_PLAYER_GAP_EN
        check("gap_ticks", gap_ticks, len - 1);
`else
        check("gap_ticks", gap_ticks, 0);
        check("valid_drop_between_digits", valid_drop, 0);
`endif
    endtask

    task automatic run_abort();
        int rises;
        int guard;
        int done_cnt;
        int busy_cnt;
        logic prev_te;
        rises = 0; guard = 0; done_cnt = 0; busy_cnt = 0; prev_te = 1'b0;
        fill_ram_random();
        @(posedge clk); #1;
        start = 1'b1;
        diff  = 2'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        while (rises < 2 && guard < 2000) begin
            tick = (guard % 10 == 9);
            @(negedge clk);
            if (tick_en && !prev_te) rises++;
            prev_te = tick_en;
            guard++;
            if (rises < 2) begin
                @(posedge clk); #1;
            end
        end
        check("abort_reached_second_show", rises, 2);
        @(posedge clk); #1;
        abort = 1'b1;
        tick  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", disp_valid, 0);
        check("abort_digit", disp_digit, BLANK_CODE);
        check("abort_tick_en", tick_en, 0);
        check("abort_addr", ram_addr, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            tick = (i % 3 == 0);
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        tick = 1'b0;
        check("abort_no_done", done_cnt, 0);
        check("abort_stays_idle", busy_cnt, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; diff = 2'd0; tick = 1'b0;
        fill_ram_random();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr", ram_addr, 0);
        check("rst_digit", disp_digit, BLANK_CODE);
        check("rst_valid", disp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tick_en", tick_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        ram[0] = 4'd3; ram[1] = 4'd7; ram[2] = 4'd1; ram[3] = 4'd9;
        run_seq(2'd0, 20, 20, 1'b0);

        for (int i = 0; i < 4; i++) ram[i] = 4'd5;
        run_seq(2'd0, 3, 15, 1'b0);

        fill_ram_random();
        run_seq(2'd3, 2, 12, 1'b1);
        fill_ram_random();
        run_seq(2'd1, 1, 8, 1'b1);
        fill_ram_random();
        run_seq(2'd2, 1, 30, 1'b1);

        run_abort();

        fill_ram_random();
        run_seq(2'd0, 1, 10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
